// File: rtl/icd_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : icd_cmd_decoder
//  Purpose  : Command decoder behind the ICD SPI target. Decodes NOP / WRITE /
//             READ headers carrying a 24-bit little-endian address, drives a
//             single-outstanding byte memory port with an ack timeout, and
//             feeds status or read data into the SPI transmit buffer.
//  Ports    : clk6x, reset          - clock, async active-high reset
//             rx_byte_i             - received SPI byte
//             rx_hdr_en_i           - header byte strobe (first after CSN)
//             rx_db_en_i            - data byte strobe
//             tx_byte_o, tx_en_o    - transmit buffer byte and load strobe
//             mem_addr_o, mem_wdata_o, mem_wr_o, mem_rd_o - memory request
//             mem_ack_i, mem_rdata_i                      - memory response
//  Revision : 1.0 - initial release
// ============================================================================
module icd_cmd_decoder #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_hdr_en_i,
  input  logic        rx_db_en_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_en_o,
  output logic [23:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i
);

  localparam logic [7:0] C_TO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] C_OP_NOP  = 4'd0;
  localparam logic [3:0] C_OP_WR   = 4'd1;
  localparam logic [3:0] C_OP_RD   = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR0  = 3'd1,
    ST_ADDR1  = 3'd2,
    ST_ADDR2  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [23:0] r_addr;
  logic        r_op_rd;
  logic        r_autoinc;
  logic        r_discard;
  logic        r_rd_pend;
  logic        r_timeout_f;
  logic        r_overrun_f;
  logic        r_badcmd_f;
  logic [7:0]  r_to_cnt;

  logic [3:0]  w_opcode;
  logic        w_busy;
  logic        w_ack;
  logic        w_to_hit;
  logic        w_done;
  logic        w_live_ack;
  logic        w_db;
  logic        w_issue_rd;
  logic [23:0] w_issue_addr;
  logic [7:0]  w_status;

  assign w_opcode = rx_byte_i[7:4];
  assign w_busy   = mem_wr_o | mem_rd_o;
  assign w_ack    = w_busy & mem_ack_i;
  // The request is high for exactly ACK_TIMEOUT cycles before being abandoned.
  assign w_to_hit = w_busy & ~mem_ack_i & (r_to_cnt == C_TO_LAST);
  assign w_done   = w_ack | w_to_hit;
  // An ack belongs to the current transaction only if no header has
  // intervened, including one arriving in the same cycle as the ack.
  assign w_live_ack = w_ack & ~r_discard & ~rx_hdr_en_i;
  assign w_db       = rx_db_en_i & ~rx_hdr_en_i;
  assign w_status   = {4'b1010, w_busy, r_timeout_f, r_overrun_f, r_badcmd_f};

  // A read is launched after the last address byte, on each RDATA byte, or
  // later if the last address byte landed while a discarded request was
  // still outstanding.
  always_comb begin
    w_issue_rd   = 1'b0;
    w_issue_addr = r_addr;
    if (!w_busy && !rx_hdr_en_i) begin
      if (w_db && (r_state == ST_ADDR2) && r_op_rd) begin
        w_issue_rd   = 1'b1;
        w_issue_addr = {rx_byte_i, r_addr[15:0]};
      end else if (w_db && (r_state == ST_RDATA)) begin
        w_issue_rd = 1'b1;
      end else if (r_rd_pend) begin
        w_issue_rd = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a header restarts the command from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (rx_hdr_en_i) begin
      case (w_opcode)
        C_OP_NOP: w_state_nxt = ST_IDLE;
        C_OP_WR,
        C_OP_RD:  w_state_nxt = ST_ADDR0;
        default:  w_state_nxt = ST_IGNORE;
      endcase
    end else if (rx_db_en_i) begin
      case (r_state)
        ST_ADDR0: w_state_nxt = ST_ADDR1;
        ST_ADDR1: w_state_nxt = ST_ADDR2;
        ST_ADDR2: w_state_nxt = r_op_rd ? ST_RDATA : ST_WDATA;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath, memory handshake, flags and transmit loading
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      tx_byte_o   <= 8'h00;
      tx_en_o     <= 1'b0;
      mem_addr_o  <= 24'h000000;
      mem_wdata_o <= 8'h00;
      mem_wr_o    <= 1'b0;
      mem_rd_o    <= 1'b0;
      r_addr      <= 24'h000000;
      r_op_rd     <= 1'b0;
      r_autoinc   <= 1'b0;
      r_discard   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_timeout_f <= 1'b0;
      r_overrun_f <= 1'b0;
      r_badcmd_f  <= 1'b0;
      r_to_cnt    <= 8'h00;
    end else begin
      tx_en_o <= 1'b0;

      // Request completion or timeout
      if (w_done) begin
        mem_wr_o  <= 1'b0;
        mem_rd_o  <= 1'b0;
        r_to_cnt  <= 8'h00;
        r_discard <= 1'b0;
        if (w_to_hit) begin
          r_timeout_f <= 1'b1;
        end
      end else if (w_busy) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end

      if (w_live_ack) begin
        if (r_autoinc) begin
          r_addr <= r_addr + 24'd1;
        end
        if (mem_rd_o) begin
          tx_byte_o <= mem_rdata_i;
          tx_en_o   <= 1'b1;
        end
      end

      if (rx_hdr_en_i) begin
        // Status reflects the flags accumulated before this header.
        tx_byte_o   <= w_status;
        tx_en_o     <= 1'b1;
        r_timeout_f <= 1'b0;
        r_overrun_f <= 1'b0;
        r_badcmd_f  <= (w_opcode != C_OP_NOP) && (w_opcode != C_OP_WR) &&
                       (w_opcode != C_OP_RD);
        r_autoinc   <= rx_byte_i[0];
        r_op_rd     <= (w_opcode == C_OP_RD);
        r_rd_pend   <= 1'b0;
        // An outstanding request keeps running, but its result is orphaned.
        r_discard   <= w_busy & ~w_done;
      end else if (w_db) begin
        case (r_state)
          ST_ADDR0: r_addr[7:0]   <= rx_byte_i;
          ST_ADDR1: r_addr[15:8]  <= rx_byte_i;
          ST_ADDR2: begin
            r_addr[23:16] <= rx_byte_i;
            if (r_op_rd && w_busy) begin
              r_rd_pend <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (w_busy) begin
              r_overrun_f <= 1'b1;
            end else begin
              mem_wdata_o <= rx_byte_i;
              mem_addr_o  <= r_addr;
              mem_wr_o    <= 1'b1;
              r_to_cnt    <= 8'h00;
            end
          end
          ST_RDATA: begin
            if (w_busy) begin
              r_overrun_f <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (w_issue_rd) begin
        mem_rd_o   <= 1'b1;
        mem_addr_o <= w_issue_addr;
        r_to_cnt   <= 8'h00;
        r_rd_pend  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/icd_cmd_decoder.md
Name: icd_cmd_decoder

Overview:
- Protocol stage directly downstream of the ICD SPI target.
- Consumes the received header and data byte strobes, decodes NOP, WRITE and READ commands with a 24-bit address, and drives a single-outstanding byte memory port.
- Feeds the SPI target's transmit buffer with a status byte or read data, so each response byte is loaded before the SPI byte boundary at which the target shifts it out.

Parameters:
- ACK_TIMEOUT, 255, clk6x cycles to wait for mem_ack_i before abandoning a request (1..255; 8-bit counter).

Ports:
- clk6x  input  1  system clock, 48MHz; the only clock.
- reset  input  1  asynchronous, active-high reset.
- rx_byte_i  input  8  received SPI byte; valid when either strobe below is high.
- rx_hdr_en_i  input  1  1-cycle pulse: first byte after CSN (header).
- rx_db_en_i  input  1  1-cycle pulse: subsequent byte.
- tx_byte_o  output  8  byte for the SPI target transmit buffer.
- tx_en_o  output  1  1-cycle pulse: load tx_byte_o into the transmit buffer.
- mem_addr_o  output  24  memory address.
- mem_wdata_o  output  8  write data.
- mem_wr_o  output  1  write request, held until ack or timeout.
- mem_rd_o  output  1  read request, held until ack or timeout.
- mem_ack_i  input  1  1-cycle completion; mem_rdata_i valid with it on reads.
- mem_rdata_i  input  8  read data.

Behaviour:
- Reset (async, active-high) values:
  - outputs: tx_byte_o=0, tx_en_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wr_o=0, mem_rd_o=0.
  - internal: state=IDLE, flags=0, timeout counter=0, discard=0, autoinc=0.
- Header format: [7:4] opcode (0=NOP, 1=WRITE, 2=READ, other=bad); [0] autoinc; [3:1] ignored.
- Status byte: {4'b1010, busy, timeout_f, overrun_f, badcmd_f}.
  - busy = mem request outstanding.
  - Flags are sticky.
- On rx_hdr_en_i, regardless of state:
  - Next cycle: tx_en_o=1, tx_byte_o=status, with flags as before this header.
  - Same cycle: clear all flags, latch autoinc; badcmd_f is then set if the opcode is bad.
  - State transitions: NOP -> IDLE; WRITE/READ -> ADDR0; bad -> IGNORE.
- If a mem request is outstanding when a header arrives:
  - The request is not cancelled; mem_wr_o/mem_rd_o stay high until ack or timeout.
  - discard=1; the resulting read data is not sent to tx.
  - discard clears on that ack or timeout.
- Address bytes, least-significant byte first: ADDR0 -> ADDR1 -> ADDR2, each on rx_db_en_i.
  - Byte 1 loads addr[7:0], byte 2 loads addr[15:8], byte 3 loads addr[23:16].
  - After the third address byte: WRITE -> WDATA. READ -> RDATA and issue a read of addr on the next cycle.
- WDATA, on each rx_db_en_i:
  - If idle: mem_wdata_o=byte, mem_wr_o=1 next cycle.
  - If busy: drop the byte, set overrun_f.
- RDATA, on ack with discard=0: tx_byte_o=mem_rdata_i and tx_en_o=1 one cycle later.
- RDATA, on each rx_db_en_i:
  - If idle: issue a read of the current addr.
  - If busy: set overrun_f; tx is not loaded, so the previous buffer content is resent.
- Auto-increment: on each ack, if autoinc=1, addr+1 mod 2^24 (0xFFFFFF wraps to 0x000000). If autoinc=0, addr is held.
- IDLE and IGNORE: rx_db_en_i is ignored, no tx load.
- Memory handshake and timeout:
  - mem_addr_o/mem_wdata_o are stable while a request is high.
  - The request drops the cycle after mem_ack_i.
  - A counter runs while a request is high. On reaching ACK_TIMEOUT: drop the request, set timeout_f, skip the increment, and send no read data to tx.
- Latency:
  - header -> tx_en_o: 1 cycle.
  - read request -> tx_en_o: 1 cycle after mem_ack_i.
  - rx strobe -> request asserted: 1 cycle.
- Simultaneous events:
  - rx_hdr_en_i has priority over mem_ack_i for state.
  - A same-cycle ack still completes the request but is treated as discarded.
  - Never two tx_en_o pulses in one cycle; header status wins.

Test Plan:
- Reset mid-operation: assert reset while mem_wr_o=1 -> all outputs 0 asynchronously, state IDLE.
- Header 0x00 -> one cycle later tx_en_o=1, tx_byte_o=0xA0; no mem activity.
- WRITE with autoinc: header 0x11, address bytes 0x34 0x12 0x00, data 0xAA 0xBB, ack after 3 cycles each:
  - writes 0xAA@0x001234 then 0xBB@0x001235.
  - next header returns 0xA0.
- READ without autoinc: header 0x20, address bytes 0xFF 0xFF 0xFF, two dummy bytes, rdata 0x5A then 0x5B:
  - both reads at 0xFFFFFF.
  - tx loads 0x5A then 0x5B.
  - READ with autoinc (header 0x21) wraps to 0x000000 after 0xFFFFFF.
- Timeout and overrun: WRITE with no ack -> after ACK_TIMEOUT cycles the request drops. A data byte during a pending request is dropped. Next header returns 0xA6.
- Bad opcode 0x70 -> following bytes ignored; next header returns 0xA1.
- Header arriving during a pending read -> ack data not loaded to tx; status shows busy=1 (0xA8).
